uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin scheduler that shares the single 8N1 UART transmitter between N requesters. It accepts one byte at a time over a valid/ready handshake and drives the transmitter's `transmit`/`data` inputs. Because the transmitter reports no busy or done status, the block times each frame with its own baud-period counter, so no frame is ever overlapped or dropped. It sits between the on-chip byte sources and the transmitter.

## Interface
- `N`, 4: number of requesters (2..8).
- `CLKS_PER_BIT`, 10416: clocks per baud period. Must equal the transmitter's baud divider (10415 + 1).
- `FRAME_BITS`, 12: baud periods reserved per byte (10 frame bits, load slot, margin). Minimum 12.
- `clk` in 1: system clock, shared with the transmitter.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in N: requester i has a byte pending.
- `req_data` in 8*N: byte of requester i in bits [8i+7:8i].
- `req_ready` out N: one-hot; byte i accepted at the edge where `req_valid[i] & req_ready[i]`.
- `tx_transmit` out 1: to transmitter `transmit`.
- `tx_data` out 8: to transmitter `data`.
- `grant_id` out $clog2(N): index of the requester currently being sent.
- `busy` out 1: high in LOAD and FRAME.
- `done` out 1: one-cycle pulse at the end of each reserved frame window.

## Operation
- States: IDLE, LOAD, FRAME.
- **IDLE**
  - `req_ready` is driven combinationally: it is the one-hot round-robin pick among `req_valid`, gated by state==IDLE.
  - Search order starts at `ptr` and wraps modulo N.
  - If any requester is valid, at the next edge:
    - `tx_data` <= picked byte.
    - `grant_id` <= pick.
    - `ptr` <= pick+1 mod N.
    - `tx_transmit` <= 1.
    - Counter is cleared.
    - State -> LOAD.
  - If no requester is valid, the block stays in IDLE and all outputs hold.
- **LOAD**
  - `tx_transmit` is held at 1 for exactly `CLKS_PER_BIT` cycles. This guarantees exactly one transmitter baud tick sees it, whatever the baud phase.
  - Then `tx_transmit` <= 0, counter is cleared, state -> FRAME.
- **FRAME**
  - `tx_transmit` = 0 for (`FRAME_BITS`-1)*`CLKS_PER_BIT` cycles.
  - In the last cycle, `done` = 1. At the next edge, state -> IDLE.
- `tx_data` and `grant_id` stay stable from accept until the next accept, because the transmitter samples `data` only on its baud tick.
- Counter width is $clog2(`FRAME_BITS`*`CLKS_PER_BIT`). It is a single down/up counter reused by LOAD and FRAME, with no wrap.
- A requester that drops `req_valid` before it is granted loses nothing. `ptr` moves only on an accept.
- `reset_n` must also drive the transmitter's reset (`reset` = ~`reset_n`), so that a mid-frame reset aborts both blocks together.

## Timing
- Reset values:
  - State = IDLE, `ptr` = 0.
  - `tx_transmit` = 0, `tx_data` = 0, `grant_id` = 0.
  - `busy` = 0, `done` = 0.
  - `req_ready` = pick over `req_valid` (with `ptr` = 0).
- Accept-to-`tx_transmit` latency: 1 cycle (registered).
- Reset asserted mid-LOAD or mid-FRAME: all outputs go to reset values immediately (asynchronous). The in-flight byte is lost and no `done` pulse is produced.
- Back-to-back acceptances are separated by exactly `FRAME_BITS`*`CLKS_PER_BIT` + 1 cycles: the whole window plus one IDLE cycle.
- When all N requesters are continuously valid, grants follow 0,1,…,N-1,0. No requester waits more than N-1 frames.
- New `req_valid` arriving during LOAD or FRAME is not acknowledged until IDLE.

## Structure
- Package `uart_pkg`:
  - `UART_CLKS_PER_BIT` = 10416.
  - `UART_FRAME_BITS` = 12.
  - State enum `arb_state_t` {IDLE, LOAD, FRAME}.
- Sub-module `rr_pick` (combinational): takes `req` [N] and `ptr`; returns a one-hot `gnt` and `idx`. It is reusable by other shared-resource schedulers.
- The top level contains the FSM, the counter and the output registers, and instantiates `Transmitter` only in the integration wrapper, not inside this block.

## Test plan
Sims use `CLKS_PER_BIT`=4 and `FRAME_BITS`=12, with a transmitter model that has a matching divider.
- Reset: hold `reset_n`=0 then release -> all outputs 0, `req_ready`=0 with no `req_valid`.
- Single byte: `req_valid[2]`=1, `data` 0xA5 -> `req_ready`=0100 for 1 cycle, `tx_transmit` high for 4 cycles, `done` 48 cycles after accept, TxD shows 0,1,0,1,0,0,1,0,1,1.
- Round-robin: all 4 valid continuously -> `grant_id` sequence 0,1,2,3,0, with accepts exactly 49 cycles apart.
- Pointer skip: `ptr`=1, only req 0 and req 3 valid -> req 3 granted first, then req 0.
- Reset mid-frame: drop `reset_n` 20 cycles into FRAME -> `busy`/`tx_transmit` go to 0 at once, no `done`, next request is served normally with a clean frame.
- Late requester: `req_valid[1]` rises during FRAME -> no `req_ready` until IDLE, granted on the first IDLE cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit scheduler.
package uart_pkg;

    localparam int unsigned UART_CLKS_PER_BIT = 10416;
    localparam int unsigned UART_FRAME_BITS   = 12;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FRAME
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping modulo N.
module rr_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx
);

    localparam int unsigned IW = $clog2(N);

    logic          found;
    logic [IW-1:0] slot;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        slot  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            slot = IW'((32'(ptr) + k) % N);
            if (!found && req[slot]) begin
                found     = 1'b1;
                gnt[slot] = 1'b1;
                idx       = slot;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one 8N1 UART transmitter among N byte sources.
// Each frame is timed locally because the transmitter gives no busy/done status.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N            = 4,
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned FRAME_BITS   = UART_FRAME_BITS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N-1:0]         req_valid,
    input  logic [8*N-1:0]       req_data,
    output logic [N-1:0]         req_ready,
    output logic                 tx_transmit,
    output logic [7:0]           tx_data,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned CW = $clog2(FRAME_BITS * CLKS_PER_BIT);
    localparam logic [CW-1:0] LOAD_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FRAME_LAST = CW'((FRAME_BITS - 1) * CLKS_PER_BIT - 1);

    arb_state_t    state_q;
    logic [IW-1:0] ptr_q;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  pick_gnt;
    logic [IW-1:0] pick_idx;
    logic [7:0]    pick_byte;

    rr_pick #(.N(N)) u_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    assign req_ready = (state_q == IDLE) ? pick_gnt : '0;

    // One-hot OR-mux of the granted requester's byte
    always_comb begin
        pick_byte = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (pick_gnt[i]) pick_byte = pick_byte | req_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            tx_transmit <= 1'b0;
            tx_data     <= '0;
            grant_id    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        tx_data     <= pick_byte;
                        grant_id    <= pick_idx;
                        ptr_q       <= IW'((32'(pick_idx) + 32'd1) % N);
                        tx_transmit <= 1'b1;
                        busy        <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= LOAD;
                    end
                end
                // Hold transmit a full baud period so exactly one baud tick sees it
                LOAD: begin
                    if (cnt_q == LOAD_LAST) begin
                        tx_transmit <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= FRAME;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                FRAME: begin
                    if (cnt_q == FRAME_LAST) begin
                        busy    <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == FRAME_LAST - CW'(1)) done <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small 8N1 transmitter model on a matching divider.
module tb_uart_tx_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned C = 4;
    localparam int unsigned F = 12;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_transmit;
    logic [7:0]  tx_data;
    logic [1:0]  grant_id;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N(N), .CLKS_PER_BIT(C), .FRAME_BITS(F)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_transmit (tx_transmit),
        .tx_data     (tx_data),
        .grant_id    (grant_id),
        .busy        (busy),
        .done        (done)
    );

    // Transmitter model: free-running baud divider, loads on a tick that sees transmit
    int unsigned div_q;
    int unsigned left_q;
    logic [9:0]  sh_q;
    int          load_cnt;
    bit          tx_bits[$];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q  <= 0;
            left_q <= 0;
            sh_q   <= '1;
        end else if (div_q == C - 1) begin
            div_q <= 0;
            if (left_q != 0) begin
                tx_bits.push_back(sh_q[0]);
                sh_q   <= {1'b1, sh_q[9:1]};
                left_q <= left_q - 1;
            end else if (tx_transmit) begin
                sh_q     <= {1'b1, tx_data, 1'b0};
                left_q   <= 10;
                load_cnt = load_cnt + 1;
            end
        end else begin
            div_q <= div_q + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // From a negedge, find the cycle where some valid&ready handshake occurs
    task automatic wait_accept(input int budget, output int cyc, output logic [3:0] oh);
        cyc = -1;
        oh  = '0;
        for (int c = 0; c < budget; c++) begin
            #1;
            if (|(req_valid & req_ready)) begin
                cyc = c;
                oh  = req_valid & req_ready;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 80; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    // One full frame from requester idx; checks latency, window length and serial bits
    task automatic serve_one(input string tag, input int idx, input logic [7:0] b,
                             input logic [9:0] exp_frame);
        int         c;
        int         hi;
        int         done_at;
        int         done_cnt;
        logic [3:0] oh;
        logic [9:0] got;
        tx_bits.delete();
        load_cnt = 0;
        hi = 0; done_at = -1; done_cnt = 0; got = '0;
        req_data[8*idx +: 8] = b;
        req_valid = 4'(1 << idx);
        wait_accept(5, c, oh);
        check({tag, "_ready"}, 32'(oh), 32'(1 << idx));
        @(negedge clk);
        req_valid = '0;
        check({tag, "_gid"}, 32'(grant_id), 32'(idx));
        check({tag, "_data"}, 32'(tx_data), 32'(b));
        check({tag, "_ready_gated"}, 32'(req_ready), 32'd0);
        for (int k = 1; k <= 48; k++) begin
            if (tx_transmit) hi++;
            if (done) begin
                done_cnt++;
                done_at = k;
            end
            @(negedge clk);
        end
        check({tag, "_tx_hi_cycles"}, 32'(hi), 32'd4);
        check({tag, "_done_cycle"}, 32'(done_at), 32'd48);
        check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_loads"}, 32'(load_cnt), 32'd1);
        check({tag, "_nbits"}, 32'(tx_bits.size()), 32'd10);
        for (int i = 0; i < 10 && i < tx_bits.size(); i++) got[i] = tx_bits[i];
        check({tag, "_txd"}, 32'(got), 32'(exp_frame));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         c;
        int         cnt;
        logic [3:0] oh;

        // Reset values
        reset_n   = 1'b0;
        req_valid = '0;
        req_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_transmit", 32'(tx_transmit), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_gid", 32'(grant_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready_none", 32'(req_ready), 32'd0);
        req_valid = 4'b1000;
        #1;
        check("rst_ready_pick", 32'(req_ready), 32'b1000);
        req_valid = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Round-robin with all requesters continuously valid
        req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_accept(60, c, oh);
            check($sformatf("rr_ready%0d", k), 32'(oh), 32'(1 << (k % 4)));
            if (k > 0) check($sformatf("rr_gap%0d", k), 32'(c + 1), 32'd49);
            @(negedge clk);
            if (k == 4) req_valid = '0;
            check($sformatf("rr_gid%0d", k), 32'(grant_id), 32'(k % 4));
            check($sformatf("rr_data%0d", k), 32'(tx_data), 32'(8'h10 + k % 4));
        end
        wait_idle("rr_idle");
        check("idle_hold_data", 32'(tx_data), 32'h10);
        check("idle_hold_gid", 32'(grant_id), 32'd0);

        // Pointer at 1 with only requesters 0 and 3 valid
        req_valid = 4'b1001;
        wait_accept(5, c, oh);
        check("skip_first", 32'(oh), 32'b1000);
        @(negedge clk);
        req_valid = 4'b0001;
        check("skip_gid3", 32'(grant_id), 32'd3);
        wait_accept(60, c, oh);
        check("skip_second", 32'(oh), 32'b0001);
        check("skip_gap", 32'(c + 1), 32'd49);
        @(negedge clk);
        req_valid = '0;
        check("skip_gid0", 32'(grant_id), 32'd0);
        wait_idle("skip_idle");

        // Single byte 0xA5 from requester 2: frame 0,1,0,1,0,0,1,0,1,1
        serve_one("a5", 2, 8'hA5, 10'b1101001010);

        // Late requester rising during FRAME is held off until IDLE
        req_data[31:24] = 8'h77;
        req_valid = 4'b1000;
        wait_accept(5, c, oh);
        check("late_first", 32'(oh), 32'b1000);
        @(negedge clk);
        req_valid = '0;
        repeat (19) @(negedge clk);
        req_data[15:8] = 8'h5A;
        req_valid = 4'b0010;
        check("late_busy", 32'(busy), 32'd1);
        wait_accept(60, c, oh);
        check("late_wait", 32'(c), 32'd29);
        check("late_ready", 32'(oh), 32'b0010);
        @(negedge clk);
        req_valid = '0;
        check("late_gid", 32'(grant_id), 32'd1);
        check("late_data", 32'(tx_data), 32'h5A);

        // Reset 20 cycles into FRAME
        repeat (23) @(negedge clk);
        check("mf_busy_pre", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mf_busy", 32'(busy), 32'd0);
        check("mf_transmit", 32'(tx_transmit), 32'd0);
        check("mf_data", 32'(tx_data), 32'd0);
        check("mf_gid", 32'(grant_id), 32'd0);
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) cnt++;
        end
        reset_n = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("mf_no_done", 32'(cnt), 32'd0);

        // Reset during LOAD drops transmit at once
        req_data[7:0] = 8'h10;
        req_valid = 4'b0001;
        wait_accept(5, c, oh);
        check("ml_ready", 32'(oh), 32'b0001);
        @(negedge clk);
        req_valid = '0;
        check("ml_transmit_pre", 32'(tx_transmit), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("ml_transmit", 32'(tx_transmit), 32'd0);
        check("ml_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Clean frame after reset: 0x3C -> 0,0,0,1,1,1,1,0,0,1
        serve_one("post_rst", 2, 8'h3C, 10'b1001111000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
